// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory and buffers returned words with their PC for the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // BUSY: response will be kept; KILL: response will be thrown away
    typedef enum logic [1:0] {IDLE, BUSY, KILL} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       tag_pc_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [31:0]       data_reg [FIFO_DEPTH];
    logic [31:0]       addr_reg [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] wr_sel;
    logic              accept, enq, deq;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a redirect while BUSY only kills if the response is not already here
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (imem_resp_valid) state_next = IDLE;
                     else if (redirect_valid) state_next = KILL;
            KILL:    if (imem_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / handshake decode; redirect masks every handshake in its cycle
    always_comb begin
        imem_req_valid = (state_reg == IDLE) && (count_reg < DEPTH_C) && !redirect_valid;
        instr_valid    = (count_reg != '0) && !redirect_valid;
        accept         = imem_req_valid && imem_req_ready;
        enq            = (state_reg == BUSY) && imem_resp_valid && !redirect_valid;
        deq            = instr_valid && instr_ready;
    end

    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_pc & ~32'h3;
        end else if (accept) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg     <= RESET_PC;
            tag_pc_reg <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            pc_reg <= pc_next;
            if (accept) begin
                tag_pc_reg <= pc_reg;
            end
            if (redirect_valid) begin
                count_reg  <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                count_reg <= count_next;
                if (enq) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                if (deq) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_sel
            assign wr_sel[gi] = enq && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Entries are reset so the head reads zero out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_reg[i] <= '0;
                addr_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_sel[i]) begin
                    data_reg[i] <= imem_rdata;
                    addr_reg[i] <= tag_pc_reg;
                end
            end
        end
    end

    assign imem_addr = pc_reg;
    assign instr_raw = data_reg[rd_ptr_reg];
    assign instr_pc  = addr_reg[rd_ptr_reg];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decoder. It owns the program counter and issues word requests to instruction memory over a valid/ready handshake. Returned words are buffered, together with their PC, in a small FIFO that feeds the decoder's instr_raw input. Taken branch, jal and jalr redirects from the execute stage flush the FIFO, cancel any in-flight fetch, and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low (0 = reset asserted).
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_addr  output  32  word-aligned fetch address (the current PC).
imem_resp_valid  input  1  read data valid; earliest one cycle after acceptance; never without an outstanding request.
imem_rdata  input  32  instruction word.
redirect_valid  input  1  control-flow redirect, single-cycle pulse.
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 0).
instr_valid  output  1  FIFO head valid toward the decoder.
instr_ready  input  1  decoder consumes the head this cycle.
instr_raw  output  32  FIFO head instruction.
instr_pc  output  32  PC of the FIFO head instruction.

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, state=IDLE, count=0, FIFO pointers=0, instr_raw=0, instr_pc=0. Outputs: instr_valid=0, imem_addr=RESET_PC.
- Handshakes: a request is accepted when imem_req_valid && imem_req_ready. A dequeue occurs when instr_valid && instr_ready.
- At most one outstanding request.
- imem_addr = pc at all times.
- imem_req_valid = (state==IDLE) && (count<FIFO_DEPTH) && !redirect_valid.
- instr_valid = (count!=0) && !redirect_valid.
- State machine:
  - IDLE (no outstanding request):
    - On accept: record tag_pc=pc, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to BUSY.
    - Without accept: stay in IDLE.
  - BUSY (live outstanding request):
    - imem_resp_valid && !redirect_valid: enqueue {imem_rdata, tag_pc}, go to IDLE.
    - redirect_valid && imem_resp_valid: drop the response, go to IDLE.
    - redirect_valid && !imem_resp_valid: go to KILL.
  - KILL (outstanding request whose response is discarded):
    - imem_resp_valid: discard the response, go to IDLE.
    - A further redirect only updates pc; state stays KILL.
- Redirect, any state: pc<=redirect_pc & ~3, count<=0, pointers<=0, no dequeue that cycle.
  - Redirect has priority over enqueue, dequeue and request issue in the same cycle.
  - The first request to the target is presented on the next cycle (from IDLE) or after the killed response retires (from BUSY or KILL).
- FIFO ordering and throughput:
  - Enqueue and dequeue in the same cycle: count unchanged, order preserved.
  - A response is always enqueued on the cycle it arrives. Space is guaranteed because requests issue only when count<FIFO_DEPTH and only one is outstanding.
  - Full (count==FIFO_DEPTH): no requests; fetch resumes the cycle after a dequeue.
  - Empty: instr_valid=0; instr_raw and instr_pc hold their last values (don't-care).
  - Peak throughput is one instruction per two cycles (issue, then response). Latency from acceptance to instr_valid is response latency + 1 cycle.
- imem_addr and imem_req_valid are stable while valid && !ready, except when a redirect withdraws the request.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000 -> requests to 0,4,8; decoder sees instr_pc 0,4,8 with matching instr_raw, in order, no gaps beyond 2-cycle cadence.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 requests issued; imem_req_valid=0 while full; the first request after instr_ready=1 goes out the cycle after the first dequeue.
- Redirect to 32'h0000_0103 while in BUSY, response 3 cycles later -> response discarded; count=0; next request addr=32'h0000_0100; first delivered instr_pc=32'h100.
- Redirect in the same cycle as imem_resp_valid and instr_ready with count=1 -> nothing enqueued, no dequeue, instr_valid=0 that cycle, count=0 next cycle.
- Redirect to 32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000.
- reset asserted asynchronously mid-BUSY with count=2 -> instr_valid=0 and imem_addr=RESET_PC immediately; after release, normal fetch from RESET_PC; any stale response is not enqueued (bench issues none).
